// File: rtl/bl_count_array_pkg.sv
// Shared Huffman-builder definitions used by the bit-length count array and
// its saturating update ALU.
//   - op_code encodings for read-modify-write ops
//   - default widths for the count array
//   - clear-sweep FSM state type
package bl_count_array_pkg;

  // Longest code length the tree builder produces.
  localparam int MAX_BL = 15;

  // Default count-array geometry (16 counters of 9 bits, 13-bit total).
  localparam int DEF_DEPTH = 16;
  localparam int DEF_AW    = 4;
  localparam int DEF_DW    = 9;
  localparam int DEF_TW    = DEF_DW + DEF_AW;

  // Op encodings.
  localparam logic [1:0] OP_RD   = 2'b00;
  localparam logic [1:0] OP_INC  = 2'b01;
  localparam logic [1:0] OP_DEC  = 2'b10;
  localparam logic [1:0] OP_INC2 = 2'b11;

  // Clear-sweep sequencer states.
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clr_state_e;

endpackage

// File: rtl/bl_count_array_sat_alu.sv
// Saturating counter update, purely combinational.
//   old_i     : current counter value
//   op_code_i : OP_RD / OP_INC / OP_DEC / OP_INC2
//   new_o     : value to write back, clamped to [0, 2^DW-1]
//   delta_o   : signed change actually applied (new_o - old_i), in -1..+2
//   sat_o     : the requested change was clamped
module bl_cnt_sat_alu
  import bl_count_array_pkg::*;
#(
  parameter int DW = DEF_DW
) (
  input  logic [DW-1:0]      old_i,
  input  logic [1:0]         op_code_i,
  output logic [DW-1:0]      new_o,
  output logic signed [2:0]  delta_o,
  output logic               sat_o
);

  // Two extra bits: one for the sign of a decrement below zero and one
  // so that (2^DW-1)+2 is still representable before clamping.
  localparam int XW = DW + 2;
  localparam logic [XW-1:0] MAXV = {2'b00, {DW{1'b1}}};

  logic signed [XW-1:0] ext;
  logic signed [XW-1:0] step;
  logic signed [XW-1:0] sum;
  logic signed [XW-1:0] diff;

  always_comb begin
    ext  = $signed({2'b00, old_i});
    step = '0;
    unique case (op_code_i)
      OP_INC:  step = XW'(1);
      OP_DEC:  step = XW'(-1);
      OP_INC2: step = XW'(2);
      default: step = '0;
    endcase
    sum   = ext + step;
    sat_o = 1'b0;
    new_o = sum[DW-1:0];
    if (sum < 0) begin
      new_o = '0;
      sat_o = 1'b1;
    end else if (sum > $signed(MAXV)) begin
      new_o = {DW{1'b1}};
      sat_o = 1'b1;
    end
    diff    = $signed({2'b00, new_o}) - ext;
    delta_o = diff[2:0];
  end

endmodule

// File: rtl/bl_count_array.sv
// Pipelined bit-length count array for the Huffman tree builder.
// DEPTH counters of DW bits with one read-modify-write op per cycle, a
// running total of all counters, sticky saturation flag and a clear sweep.
//
// Ports:
//   clk, rstN          clock, asynchronous active-low reset
//   clr_start          pulse: start clear sweep (ignored while sweeping)
//   op_valid/op_ready  op handshake
//   op_addr, op_code   counter index, 00 read / 01 +1 / 10 -1 / 11 +2
//   rd_valid, rd_data  pre-op value of op_addr, one cycle after acceptance
//   aux_addr/aux_data  independent registered read port (write-first)
//   total              sum of all counters
//   sat_err            sticky, set by any clamped op
//   busy               high for exactly DEPTH cycles during a sweep
//
// Handshake: an op is accepted on a rising edge where op_valid && op_ready.
// op_ready is registered and never depends on op_valid; it is low exactly
// while busy is high.
module bl_count_array
  import bl_count_array_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int AW    = DEF_AW,
  parameter int DW    = DEF_DW,
  parameter int TW    = DEF_TW
) (
  input  logic          clk,
  input  logic          rstN,
  input  logic          clr_start,
  input  logic          op_valid,
  output logic          op_ready,
  input  logic [AW-1:0] op_addr,
  input  logic [1:0]    op_code,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  input  logic [AW-1:0] aux_addr,
  output logic [DW-1:0] aux_data,
  output logic [TW-1:0] total,
  output logic          sat_err,
  output logic          busy
);

  logic [DW-1:0] cnt_q [DEPTH];

  // Registered op (S1), processed in the following cycle (S2).
  logic          op_valid_q;
  logic [AW-1:0] op_addr_q;
  logic [1:0]    op_code_q;

  logic          rd_valid_q;
  logic [DW-1:0] rd_data_q;
  logic [DW-1:0] aux_data_q;
  logic [TW-1:0] total_q;
  logic          sat_err_q;

  clr_state_e    state_q;
  logic [AW-1:0] idx_q;
  logic          busy_q;
  logic          op_ready_q;

  logic          accept;
  logic          op_wr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [DW-1:0] fwd_rd;
  logic [DW-1:0] fwd_aux;

  logic [DW-1:0]       alu_new;
  logic signed [2:0]   alu_delta;
  logic                alu_sat;
  logic signed [TW:0]  tot_sum;

  // rd_data_q already holds the pre-op value of the op in S2, so it is the
  // ALU operand; no second array read is needed.
  bl_cnt_sat_alu #(.DW(DW)) u_alu (
    .old_i     (rd_data_q),
    .op_code_i (op_code_q),
    .new_o     (alu_new),
    .delta_o   (alu_delta),
    .sat_o     (alu_sat)
  );

  assign accept = op_valid && op_ready_q;

  // An S2 op is dropped when a sweep is starting or running; its rd_data
  // has already been produced.
  assign op_wr = op_valid_q && (state_q == ST_IDLE) && !clr_start;

  // Single array write port shared by the sweep and the S2 writeback.
  always_comb begin
    wr_en   = 1'b0;
    wr_addr = op_addr_q;
    wr_data = alu_new;
    if (state_q == ST_CLEAR) begin
      wr_en   = 1'b1;
      wr_addr = idx_q;
      wr_data = '0;
    end else if (op_wr) begin
      wr_en = 1'b1;
    end
  end

  // Forward the write landing on this edge so a back-to-back op (or the aux
  // port) sees the committed value.
  assign fwd_rd  = (wr_en && (wr_addr == op_addr))  ? wr_data : cnt_q[op_addr];
  assign fwd_aux = (wr_en && (wr_addr == aux_addr)) ? wr_data : cnt_q[aux_addr];

  assign tot_sum = $signed({1'b0, total_q}) +
                   $signed({{(TW-2){alu_delta[2]}}, alu_delta});

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      for (int i = 0; i < DEPTH; i++) cnt_q[i] <= '0;
    end else if (wr_en) begin
      cnt_q[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      op_valid_q <= 1'b0;
      op_addr_q  <= '0;
      op_code_q  <= OP_RD;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
      aux_data_q <= '0;
    end else begin
      op_valid_q <= accept;
      rd_valid_q <= accept;
      aux_data_q <= fwd_aux;
      if (accept) begin
        op_addr_q <= op_addr;
        op_code_q <= op_code;
        rd_data_q <= fwd_rd;
      end
    end
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      total_q   <= '0;
      sat_err_q <= 1'b0;
    end else if ((state_q == ST_CLEAR) && (idx_q == '0)) begin
      total_q   <= '0;
      sat_err_q <= 1'b0;
    end else if (op_wr) begin
      total_q <= tot_sum[TW-1:0];
      if (alu_sat) sat_err_q <= 1'b1;
    end
  end

  // Clear-sweep sequencer.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q    <= ST_IDLE;
      idx_q      <= '0;
      busy_q     <= 1'b0;
      op_ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (clr_start) begin
            state_q    <= ST_CLEAR;
            idx_q      <= '0;
            busy_q     <= 1'b1;
            op_ready_q <= 1'b0;
          end
        end
        ST_CLEAR: begin
          idx_q <= idx_q + 1'b1;
          if (idx_q == AW'(DEPTH - 1)) begin
            state_q    <= ST_IDLE;
            busy_q     <= 1'b0;
            op_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_ready = op_ready_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign aux_data = aux_data_q;
  assign total    = total_q;
  assign sat_err  = sat_err_q;
  assign busy     = busy_q;

endmodule

// File: tb/tb_bl_count_array.sv
module tb_bl_count_array;
  import bl_count_array_pkg::*;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       clr_start = 1'b0;
  logic       op_valid = 1'b0;
  logic       op_ready;
  logic [3:0] op_addr = '0;
  logic [1:0] op_code = OP_RD;
  logic       rd_valid;
  logic [8:0] rd_data;
  logic [3:0] aux_addr = '0;
  logic [8:0] aux_data;
  logic [12:0] total;
  logic       sat_err;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  bl_count_array dut (
    .clk       (clk),
    .rstN      (rstN),
    .clr_start (clr_start),
    .op_valid  (op_valid),
    .op_ready  (op_ready),
    .op_addr   (op_addr),
    .op_code   (op_code),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .aux_addr  (aux_addr),
    .aux_data  (aux_data),
    .total     (total),
    .sat_err   (sat_err),
    .busy      (busy)
  );

  // driver / checker tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one op for one cycle; rd_data is visible right after the
  // accepting edge. op_valid is left high so calls can be chained.
  task automatic do_op(input int a, input logic [1:0] c, input int exp_rd, input string tag);
    op_valid = 1'b1;
    op_addr  = 4'(a);
    op_code  = c;
    step();
    chk({tag, "_rdv"}, 32'(rd_valid), 1);
    chk(tag, 32'(rd_data), 32'(exp_rd));
  endtask

  task automatic idle();
    op_valid = 1'b0;
    step();
    chk("idle_rdv", 32'(rd_valid), 0);
  endtask

  int cyc;
  int rdv_seen;
  int rdy_seen;

  initial begin
    // ---- reset state
    step();
    step();
    chk("rst_rd_valid", 32'(rd_valid), 0);
    chk("rst_rd_data",  32'(rd_data), 0);
    chk("rst_aux_data", 32'(aux_data), 0);
    chk("rst_total",    32'(total), 0);
    chk("rst_sat_err",  32'(sat_err), 0);
    chk("rst_busy",     32'(busy), 0);
    chk("rst_op_ready", 32'(op_ready), 1);
    rstN = 1'b1;
    step();

    // ---- read every address after reset
    for (int a = 0; a < 16; a++) do_op(a, OP_RD, 0, "rd_init");
    idle();
    chk("rd_init_total", 32'(total), 0);

    // ---- back-to-back +1 on addr 5
    do_op(5, OP_INC, 0, "b2b_0");
    do_op(5, OP_INC, 1, "b2b_1");
    do_op(5, OP_INC, 2, "b2b_2");
    do_op(5, OP_INC, 3, "b2b_3");
    aux_addr = 4'd5;
    idle();
    chk("b2b_aux", 32'(aux_data), 4);
    chk("b2b_total", 32'(total), 4);

    // ---- mixed ops on addr 3
    do_op(3, OP_INC2, 0, "mix_0");
    do_op(3, OP_DEC,  2, "mix_1");
    do_op(3, OP_INC2, 1, "mix_2");
    idle();
    chk("mix_total", 32'(total), 7);
    chk("mix_sat", 32'(sat_err), 0);
    do_op(3, OP_RD, 3, "mix_rd");
    do_op(3, OP_DEC, 3, "dec_0");
    do_op(3, OP_DEC, 2, "dec_1");
    do_op(3, OP_DEC, 1, "dec_2");
    do_op(3, OP_DEC, 0, "dec_3");
    do_op(3, OP_DEC, 0, "dec_4");
    idle();
    chk("dec_total", 32'(total), 4);
    chk("dec_sat", 32'(sat_err), 1);

    // ---- clear sweep with ops held; second clr_start mid-sweep is ignored
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    op_valid  = 1'b1;
    op_addr   = 4'd5;
    op_code   = OP_INC;
    cyc = 0;
    rdv_seen = 0;
    rdy_seen = 0;
    for (int i = 0; i < 40 && busy; i++) begin
      cyc++;
      if (rd_valid) rdv_seen++;
      if (op_ready) rdy_seen++;
      clr_start = (i == 4);
      step();
    end
    clr_start = 1'b0;
    op_valid  = 1'b0;
    chk("clr_busy_cycles", 32'(cyc), 16);
    chk("clr_rd_valid_seen", 32'(rdv_seen), 0);
    chk("clr_op_ready_seen", 32'(rdy_seen), 0);
    chk("clr_op_ready_after", 32'(op_ready), 1);
    chk("clr_total", 32'(total), 0);
    chk("clr_sat", 32'(sat_err), 0);
    for (int a = 0; a < 16; a++) do_op(a, OP_RD, 0, "clr_rd");
    idle();

    // ---- saturation on addr 7
    for (int i = 0; i < 255; i++) do_op(7, OP_INC2, 2 * i, "pre");
    idle();
    chk("pre_total", 32'(total), 510);
    chk("pre_sat", 32'(sat_err), 0);
    do_op(7, OP_INC2, 510, "sat_inc2");
    idle();
    chk("sat_total", 32'(total), 511);
    chk("sat_flag", 32'(sat_err), 1);
    do_op(7, OP_RD, 511, "sat_rd");
    do_op(7, OP_INC, 511, "sat_inc");
    idle();
    chk("sat_total2", 32'(total), 511);
    aux_addr = 4'd7;
    do_op(7, OP_RD, 511, "sat_rd2");
    chk("sat_aux", 32'(aux_data), 511);
    idle();

    // ---- asynchronous reset in cycle 8 of a sweep
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    repeat (7) step();
    chk("mid_busy", 32'(busy), 1);
    chk("mid_aux_pre", 32'(aux_data), 511);
    rstN = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_op_ready", 32'(op_ready), 1);
    chk("arst_rd_data", 32'(rd_data), 0);
    chk("arst_rd_valid", 32'(rd_valid), 0);
    chk("arst_aux_data", 32'(aux_data), 0);
    chk("arst_total", 32'(total), 0);
    chk("arst_sat", 32'(sat_err), 0);
    step();
    rstN = 1'b1;
    step();
    chk("rel_op_ready", 32'(op_ready), 1);
    chk("rel_busy", 32'(busy), 0);
    do_op(7, OP_RD, 0, "rel_rd7");
    idle();
    chk("rel_aux", 32'(aux_data), 0);

    // ---- report
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
